// File: rtl/bit_rate_meter_pkg.sv
// Shared widths and saturating add for the bit-rate meter.
// Optional peak tracking: BIT_RATE_METER_PEAK_EN.
package bit_rate_meter_pkg;

  localparam int CNT_WIDTH_DEF = 32;
  localparam int INC_WIDTH_DEF = 8;
  localparam int SUM_W         = 64;

  typedef logic [SUM_W:0] sat_sum_t;

  // Returns {overflow, sum clamped to w bits}.
  function automatic sat_sum_t sat_add(
    input logic [SUM_W-1:0] acc,
    input logic [SUM_W-1:0] inc,
    input int unsigned      w
  );
    sat_sum_t s;
    sat_sum_t lim;
    sat_sum_t one;
    one = sat_sum_t'(1);
    s   = {1'b0, acc} + {1'b0, inc};
    lim = (one << w) - one;
    if (s > lim) return {1'b1, lim[SUM_W-1:0]};
    return {1'b0, s[SUM_W-1:0]};
  endfunction

endpackage

// File: rtl/bit_rate_meter_ch.sv
// One channel: accumulator, saturation flag, snapshot, optional peak.
// Optional peak tracking: BIT_RATE_METER_PEAK_EN.
module bit_rate_meter_ch
  import bit_rate_meter_pkg::*;
#(
  parameter int INC_WIDTH = INC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 a_rst_n_i,
  input  logic                 en_i,
  input  logic                 bnd_i,
  input  logic                 valid_i,
  input  logic [INC_WIDTH-1:0] bits_i,
`ifdef BIT_RATE_METER_PEAK_EN
  input  logic                 peak_clr_i,
  output logic [CNT_WIDTH-1:0] peak_o,
`endif
  output logic [CNT_WIDTH-1:0] rate_o,
  output logic                 sat_o
);

  logic [CNT_WIDTH-1:0] acc;
  logic                 flag;
  logic [INC_WIDTH-1:0] inc;
  sat_sum_t             r;
  logic [CNT_WIDTH-1:0] sum;
  logic                 ovf;
  logic                 unused_hi;

  assign inc       = valid_i ? bits_i : '0;
  assign r         = sat_add(SUM_W'(acc), SUM_W'(inc), CNT_WIDTH);
  assign sum       = r[CNT_WIDTH-1:0];
  assign ovf       = r[SUM_W];
  assign unused_hi = ^r[SUM_W-1:CNT_WIDTH];

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      acc    <= '0;
      flag   <= 1'b0;
      rate_o <= '0;
      sat_o  <= 1'b0;
    end else if (!en_i) begin
      acc  <= '0;
      flag <= 1'b0;
    end else if (bnd_i) begin
      rate_o <= sum;
      sat_o  <= flag | ovf;
      acc    <= '0;
      flag   <= 1'b0;
    end else begin
      acc  <= sum;
      flag <= flag | ovf;
    end
  end

`ifdef BIT_RATE_METER_PEAK_EN
  // A snapshot on the clearing edge wins over the clear.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      peak_o <= '0;
    end else if (bnd_i) begin
      if (peak_clr_i || sum > peak_o) peak_o <= sum;
    end else if (peak_clr_i) begin
      peak_o <= '0;
    end
  end
`endif

endmodule

// File: rtl/bit_rate_meter_mc.sv
// Multi-channel windowed bit-rate meter; shared window counter.
// Optional peak tracking: BIT_RATE_METER_PEAK_EN.
module bit_rate_meter_mc
  import bit_rate_meter_pkg::*;
#(
  parameter int CLK_MHZ_VAL  = 100,
  parameter int WINDOW_TICKS = CLK_MHZ_VAL * 1000000,
  parameter int CH_NR        = 4,
  parameter int INC_WIDTH    = INC_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         a_rst_n_i,
  input  logic                         en_i,
  input  logic [CH_NR-1:0]             beat_valid_i,
  input  logic [CH_NR*INC_WIDTH-1:0]   beat_bits_i,
`ifdef BIT_RATE_METER_PEAK_EN
  input  logic                         peak_clr_i,
  output logic [CH_NR*CNT_WIDTH-1:0]   peak_o,
`endif
  output logic [CH_NR*CNT_WIDTH-1:0]   rate_o,
  output logic                         rate_valid_o,
  output logic [CH_NR-1:0]             sat_o
);

  localparam int CW = $clog2(WINDOW_TICKS);
  localparam logic [CW-1:0] LAST = CW'(WINDOW_TICKS - 1);

  logic [CW-1:0] win_cnt;
  logic          bnd;

  assign bnd = en_i && (win_cnt == LAST);

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      win_cnt      <= '0;
      rate_valid_o <= 1'b0;
    end else begin
      rate_valid_o <= bnd;
      if (!en_i || bnd) win_cnt <= '0;
      else              win_cnt <= win_cnt + CW'(1);
    end
  end

  for (genvar k = 0; k < CH_NR; k++) begin : g_ch
    bit_rate_meter_ch #(
      .INC_WIDTH (INC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk_i      (clk_i),
      .a_rst_n_i  (a_rst_n_i),
      .en_i       (en_i),
      .bnd_i      (bnd),
      .valid_i    (beat_valid_i[k]),
      .bits_i     (beat_bits_i[k*INC_WIDTH +: INC_WIDTH]),
`ifdef BIT_RATE_METER_PEAK_EN
      .peak_clr_i (peak_clr_i),
      .peak_o     (peak_o[k*CNT_WIDTH +: CNT_WIDTH]),
`endif
      .rate_o     (rate_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .sat_o      (sat_o[k])
    );
  end

endmodule

// File: tb/tb_bit_rate_meter_mc.sv
// Directed bench for bit_rate_meter_mc (window 10 and window 20).
// Peak checks follow BIT_RATE_METER_PEAK_EN.
module tb_bit_rate_meter_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en = 1'b0;
  logic [1:0]  bv = '0;
  logic [7:0]  bb = '0;
  logic        pclr = 1'b0;
  logic [15:0] rate;
  logic        rv;
  logic [1:0]  sat;
  logic [15:0] peak;

  logic        en2 = 1'b0;
  logic [1:0]  bv2 = '0;
  logic [7:0]  bb2 = '0;
  logic        pclr2 = 1'b0;
  logic [15:0] rate2;
  logic        rv2;
  logic [1:0]  sat2;
  logic [15:0] peak2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_rate_meter_mc #(
    .WINDOW_TICKS (10),
    .CH_NR        (2),
    .INC_WIDTH    (4),
    .CNT_WIDTH    (8)
  ) dut (
    .clk_i        (clk),
    .a_rst_n_i    (rst_n),
    .en_i         (en),
    .beat_valid_i (bv),
    .beat_bits_i  (bb),
`ifdef BIT_RATE_METER_PEAK_EN
    .peak_clr_i   (pclr),
    .peak_o       (peak),
`endif
    .rate_o       (rate),
    .rate_valid_o (rv),
    .sat_o        (sat)
  );

  bit_rate_meter_mc #(
    .WINDOW_TICKS (20),
    .CH_NR        (2),
    .INC_WIDTH    (4),
    .CNT_WIDTH    (8)
  ) dut20 (
    .clk_i        (clk),
    .a_rst_n_i    (rst_n),
    .en_i         (en2),
    .beat_valid_i (bv2),
    .beat_bits_i  (bb2),
`ifdef BIT_RATE_METER_PEAK_EN
    .peak_clr_i   (pclr2),
    .peak_o       (peak2),
`endif
    .rate_o       (rate2),
    .rate_valid_o (rv2),
    .sat_o        (sat2)
  );

`ifndef BIT_RATE_METER_PEAK_EN
  assign peak  = '0;
  assign peak2 = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    chk("rst_rate", 32'(rate), 0);
    chk("rst_rv", 32'(rv), 0);
    chk("rst_sat", 32'(sat), 0);
    rst_n = 1'b1;
    step(1);

    // ch0 one bit per cycle
    en = 1'b1; bv = 2'b01; bb = 8'h01;
    step(9);
    chk("rv_early", 32'(rv), 0);
    step(1);
    chk("rv_w1", 32'(rv), 1);
    chk("rate_w1", 32'(rate[7:0]), 10);
    chk("sat_w1", 32'(sat), 0);
    chk("rate1_w1", 32'(rate[15:8]), 0);
    step(1);
    chk("rv_pulse", 32'(rv), 0);
    step(9);
    chk("rv_w2", 32'(rv), 1);
    chk("rate_w2", 32'(rate[7:0]), 10);

    // single beat in the boundary cycle
    bv = 2'b00;
    step(9);
    bv = 2'b01; bb = 8'h07;
    step(1);
    bv = 2'b00;
    chk("bnd_rv", 32'(rv), 1);
    chk("bnd_rate", 32'(rate[7:0]), 7);
    step(10);
    chk("post_rv", 32'(rv), 1);
    chk("post_rate", 32'(rate[7:0]), 0);

    // enable gap mid-window
    bv = 2'b01; bb = 8'h02;
    step(10);
    chk("gap_pre", 32'(rate[7:0]), 20);
    step(5);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("gap_rv", 32'(rv), 0);
    end
    chk("gap_hold", 32'(rate[7:0]), 20);
    en = 1'b1;
    step(9);
    chk("gap_rv9", 32'(rv), 0);
    step(1);
    chk("gap_rv10", 32'(rv), 1);
    chk("gap_rate", 32'(rate[7:0]), 20);

    // async reset mid-window
    step(6);
    rst_n = 1'b0;
    #1;
    chk("arst_rate", 32'(rate), 0);
    chk("arst_rv", 32'(rv), 0);
    chk("arst_sat", 32'(sat), 0);
    chk("arst_peak", 32'(peak), 0);
    step(1);
    rst_n = 1'b1;
    step(9);
    chk("arst_rv9", 32'(rv), 0);
    step(1);
    chk("arst_rv10", 32'(rv), 1);
    chk("arst_rate2", 32'(rate[7:0]), 20);

`ifdef BIT_RATE_METER_PEAK_EN
    pclr = 1'b1; bv = 2'b01; bb = 8'h05;
    step(1);
    pclr = 1'b0; bv = 2'b00;
    chk("pk_clr", 32'(peak[7:0]), 0);
    step(9);
    chk("pk_rate5", 32'(rate[7:0]), 5);
    chk("pk_5", 32'(peak[7:0]), 5);
    bv = 2'b01; bb = 8'h09;
    step(1);
    bv = 2'b00;
    step(9);
    chk("pk_rate9", 32'(rate[7:0]), 9);
    chk("pk_9", 32'(peak[7:0]), 9);
    bv = 2'b01; bb = 8'h03;
    step(1);
    bv = 2'b00;
    step(8);
    chk("pk_hold", 32'(peak[7:0]), 9);
    pclr = 1'b1;
    step(1);
    pclr = 1'b0;
    chk("pk_rate3", 32'(rate[7:0]), 3);
    chk("pk_clr_snap", 32'(peak[7:0]), 3);
`endif

    // saturation on window 20
    en2 = 1'b1; bv2 = 2'b10; bb2 = 8'hF0;
    step(19);
    chk("sat_rv19", 32'(rv2), 0);
    step(1);
    chk("sat_rv20", 32'(rv2), 1);
    chk("sat_rate", 32'(rate2[15:8]), 255);
    chk("sat_flag", 32'(sat2), 2);
    chk("sat_ch0", 32'(rate2[7:0]), 0);
    bb2 = 8'h10;
    step(20);
    chk("unsat_rv", 32'(rv2), 1);
    chk("unsat_rate", 32'(rate2[15:8]), 20);
    chk("unsat_flag", 32'(sat2), 0);
`ifdef BIT_RATE_METER_PEAK_EN
    chk("sat_peak", 32'(peak2[15:8]), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
